// File: rtl/multiplier_array_pipe.sv
// Pipelined array multiplier with per-operand signed/unsigned mode.
// The partial-product rows are split over STAGES register stages, with
// ceil(WIDTH/STAGES) rows per stage. A global advance enable moves the
// whole pipe one slot at a time. Bubbles are kept and never collapsed.
//
// Ports:
//   clk, rst_n  - clock; asynchronous active-low reset
//   in_valid    - operands on a/b/is_signed are valid
//   in_ready    - pipe advances this edge (combinational)
//   a, b        - WIDTH-bit multiplicand / multiplier
//   is_signed   - 1: two's complement operands, 0: unsigned operands
//   out_valid   - y holds a valid product
//   out_ready   - consumer takes y this edge
//   y           - 2*WIDTH-bit registered product
module multiplier_array_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned R  = (WIDTH + STAGES - 1) / STAGES;

  // Slot k holds the operands and valid bit that entered k edges ago.
  // Slot 0's partial sum is held at zero.
  logic [PW-1:0]    ps_q [0:STAGES];
  logic [WIDTH-1:0] a_q  [0:STAGES];
  logic [WIDTH-1:0] b_q  [0:STAGES];
  logic             sg_q [0:STAGES];
  logic             v_q  [0:STAGES];

  logic [PW-1:0]    sum_d [1:STAGES];
  logic             adv;

  // Adds rows (s-1)*R .. min(s*R,WIDTH)-1 onto acc. In signed mode a's MSB
  // row has negative weight, so that row is subtracted.
  function automatic logic [PW-1:0] add_rows(
    input logic [PW-1:0]    acc,
    input logic [WIDTH-1:0] av,
    input logic [WIDTH-1:0] bv,
    input logic             sg,
    input int unsigned      s
  );
    logic [PW-1:0] bx;
    logic [PW-1:0] sum;
    bx  = sg ? {{WIDTH{bv[WIDTH-1]}}, bv} : {{WIDTH{1'b0}}, bv};
    sum = acc;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i >= (s - 1) * R && i < s * R && av[i]) begin
        if (sg && i == WIDTH - 1) sum = sum - (bx << i);
        else                      sum = sum + (bx << i);
      end
    end
    return sum;
  endfunction

  // Whole pipe moves only when the output slot is empty or being taken.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES];
  assign y         = ps_q[STAGES];

  // Per-stage row accumulation.
  always_comb begin
    for (int unsigned s = 1; s <= STAGES; s++) begin
      sum_d[s] = add_rows(ps_q[s-1], a_q[s-1], b_q[s-1], sg_q[s-1], s);
    end
  end

  // Slot registers: shift one slot per advance, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= STAGES; k++) begin
        ps_q[k] <= '0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        sg_q[k] <= 1'b0;
        v_q[k]  <= 1'b0;
      end
    end else if (adv) begin
      ps_q[0] <= '0;
      a_q[0]  <= a;
      b_q[0]  <= b;
      sg_q[0] <= is_signed;
      v_q[0]  <= in_valid;
      for (int unsigned k = 1; k <= STAGES; k++) begin
        ps_q[k] <= sum_d[k];
        a_q[k]  <= a_q[k-1];
        b_q[k]  <= b_q[k-1];
        sg_q[k] <= sg_q[k-1];
        v_q[k]  <= v_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_multiplier_array_pipe.sv
// Self-checking bench: five instances with different (WIDTH,STAGES) share
// clock, reset and handshake lines. A delay-line model per instance gives
// the expected out_valid/y/in_ready on every cycle. Directed checks pin
// literal products and latencies on the (8,2) instance.
module tb_multiplier_array_pipe;

  localparam int NI = 5;
  localparam int unsigned W_L [NI] = '{8, 4, 8, 8, 16};
  localparam int unsigned S_L [NI] = '{2, 1, 3, 8, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a_v  [NI];
  logic [15:0] b_v  [NI];
  logic        sg_v [NI];
  logic [31:0] y_v  [NI];
  logic        ov   [NI];
  logic        ir   [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int unsigned W = W_L[gi];
    localparam int unsigned S = S_L[gi];
    logic [2*W-1:0] yw;
    multiplier_array_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir[gi]),
      .a         (a_v[gi][W-1:0]),
      .b         (b_v[gi][W-1:0]),
      .is_signed (sg_v[gi]),
      .out_valid (ov[gi]),
      .out_ready (out_ready),
      .y         (yw)
    );
    assign y_v[gi] = 32'(yw);
  end

  // Model: index 0 is what the output shows, index S is the newest entry.
  logic        mv  [NI][9];
  logic [31:0] my  [NI][9];
  logic        acc [NI];

  int tot = 0;
  int bad = 0;

  function automatic logic [31:0] ref_prod(int unsigned w, logic [15:0] av,
                                           logic [15:0] bv, logic s);
    longint x, z, m;
    m = (longint'(1) << (2 * w)) - 1;
    x = longint'(av);
    z = longint'(bv);
    if (s && av[w-1]) x = x - (longint'(1) << w);
    if (s && bv[w-1]) z = z - (longint'(1) << w);
    return 32'((x * z) & m);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 9; j++) begin
        mv[i][j] = 1'b0;
        my[i][j] = '0;
      end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int s;
      s = int'(S_L[i]);
      if (!mv[i][0] || out_ready) begin
        for (int j = 0; j < s; j++) begin
          mv[i][j] = mv[i][j+1];
          my[i][j] = my[i][j+1];
        end
        mv[i][s] = in_valid;
        my[i][s] = ref_prod(W_L[i], a_v[i], b_v[i], sg_v[i]);
        acc[i]   = in_valid;
      end else begin
        acc[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(mv[i][0]));
      if (mv[i][0]) chk($sformatf("y[%0d]", i), 64'(y_v[i]), 64'(my[i][0]));
      chk($sformatf("in_ready[%0d]", i), 64'(ir[i]), 64'(!mv[i][0] || out_ready));
    end
  endtask

  // One clock: model follows the edge, outputs are compared at the negedge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive_rand();
    for (int i = 0; i < NI; i++) begin
      a_v[i]  = 16'($urandom) & 16'((1 << W_L[i]) - 1);
      b_v[i]  = 16'($urandom) & 16'((1 << W_L[i]) - 1);
      sg_v[i] = 1'($urandom % 2);
    end
  endtask

  task automatic directed(string nm, logic [15:0] av, logic [15:0] bv,
                          logic s, logic [31:0] exp);
    drive_rand();
    a_v[0] = av; b_v[0] = bv; sg_v[0] = s;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk({nm, "_early"}, 64'(ov[0]), 64'(0));
    cycle();
    chk({nm, "_ov"}, 64'(ov[0]), 64'(1));
    chk({nm, "_y"}, 64'(y_v[0]), 64'(exp));
  endtask

  initial begin
    int first, last, nov, idx;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NI; i++) begin
      a_v[i] = '0; b_v[i] = '0; sg_v[i] = 1'b0; acc[i] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_ov[%0d]", i), 64'(ov[i]), 64'(0));
      chk($sformatf("rst_y[%0d]", i), 64'(y_v[i]), 64'(0));
      chk($sformatf("rst_ir[%0d]", i), 64'(ir[i]), 64'(1));
    end
    rst_n = 1'b1;

    // Unsigned limits, signed corners, per-operand mode bit.
    directed("u_max",   16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01);
    directed("u_zero",  16'h0000, 16'h00C8, 1'b0, 32'h00000000);
    directed("s_mm",    16'h0080, 16'h0080, 1'b1, 32'h00004000);
    directed("s_m1p1",  16'h00FF, 16'h0001, 1'b1, 32'h0000FFFF);
    directed("s_pm",    16'h007F, 16'h0080, 1'b1, 32'h0000C080);
    directed("u_ff01",  16'h00FF, 16'h0001, 1'b0, 32'h000000FF);

    // Back-to-back stream of 16 with alternating mode.
    first = -1; last = -1; nov = 0;
    for (int k = 0; k < 22; k++) begin
      drive_rand();
      sg_v[0] = 1'(k % 2);
      in_valid = (k < 16);
      cycle();
      if (ov[0]) begin
        nov++;
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("stream_count", 64'(nov), 64'(16));
    chk("stream_span", 64'(last - first + 1), 64'(16));
    chk("stream_latency", 64'(first), 64'(2));

    // Back-pressure: fill, freeze 5 cycles, release, drain.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_rand();
      cycle();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_rand();
      cycle();
      chk("stall_ir", 64'(ir[0]), 64'(0));
      chk("stall_ov", 64'(ov[0]), 64'(1));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_rand();
      cycle();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) cycle();

    // Bubble pattern 1,0,1 reappears STAGES later.
    drive_rand(); in_valid = 1'b1; cycle();
    drive_rand(); in_valid = 1'b0; cycle();
    drive_rand(); in_valid = 1'b1; cycle();
    chk("bubble_0", 64'(ov[0]), 64'(1));
    in_valid = 1'b0;
    cycle(); chk("bubble_1", 64'(ov[0]), 64'(0));
    cycle(); chk("bubble_2", 64'(ov[0]), 64'(1));
    cycle(); chk("bubble_3", 64'(ov[0]), 64'(0));

    // Reset mid-stream.
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_rand();
      cycle();
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mrst_ov[%0d]", i), 64'(ov[i]), 64'(0));
      chk($sformatf("mrst_y[%0d]", i), 64'(y_v[i]), 64'(0));
    end
    cycle();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("post_rst_ov", 64'(ov[0]), 64'(0));
    end

    // Sweep: exhaustive on the 4-bit instance, random elsewhere, random stalls.
    idx = 0; in_valid = 1'b1;
    for (int k = 0; k < 3000 && idx < 512; k++) begin
      drive_rand();
      out_ready = (($urandom % 4) != 0);
      a_v[1]  = 16'(idx % 16);
      b_v[1]  = 16'((idx / 16) % 16);
      sg_v[1] = 1'(idx / 256);
      cycle();
      if (acc[1]) idx++;
    end
    chk("sweep_done", 64'(idx), 64'(512));
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) cycle();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
